fir_out_stream: RTL

//  Downstream stage of the 32-tap FIR. Consumes the filter's 14-bit output on each ce strobe, applies a

---
 rtl/fir32_pkg.sv | 34 +++
 rtl/fir_out_stream_if.sv | 10 +
 rtl/fir_out_fifo.sv | 49 ++++
 rtl/fir_out_stream.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/fir32_pkg.sv
// Shared widths, saturation limits and the Q2.14 rescale/clamp helper for the FIR output stage.
package fir32_pkg;

  localparam int DATA_W    = 14;
  localparam int GAIN_W    = 16;
  localparam int GAIN_FRAC = 14;
  localparam int PROD_W    = 30;
  localparam int OUT_W     = 32;
  localparam int SAT_MAX   = 8191;
  localparam int SAT_MIN   = -8192;

  typedef enum logic {PK_LO = 1'b0, PK_HI = 1'b1} pack_state_e;

  typedef struct packed {
    logic                     sat;
    logic signed [DATA_W-1:0] y;
  } sat_res_t;

  // Arithmetic shift floors toward -inf; anything outside 14-bit signed range is clipped.
  function automatic sat_res_t sat14(input logic signed [PROD_W-1:0] prod);
    logic signed [PROD_W-1:0] sh;
    sat_res_t                 r;
    sh    = prod >>> GAIN_FRAC;
    r.sat = 1'b1;
    if (sh > PROD_W'(SAT_MAX))      r.y = DATA_W'(SAT_MAX);
    else if (sh < PROD_W'(SAT_MIN)) r.y = DATA_W'(SAT_MIN);
    else begin
      r.y   = sh[DATA_W-1:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_out_stream_if.sv
// AXI4-Stream link from the FIR output stage toward the DMA.
interface fir_out_stream_if #(parameter int DW = 32);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/fir_out_fifo.sv
// First-word fall-through FIFO: head entry is presented combinationally whenever non-empty.
module fir_out_fifo #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (i_wr) r_wptr <= r_wptr + 1'b1;
      if (i_rd) r_rptr <= r_rptr + 1'b1;
      case ({i_wr, i_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr) r_mem[r_wptr] <= i_wdata;
  end

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_level = r_level;
  // Gate the head so the stream outputs read zero after reset / when idle.
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/fir_out_stream.sv
// FIR output stage: Q2.14 gain with saturation, two-sample packing, framed FWFT stream toward the DMA.
//   state | meaning
//   PK_LO | waiting for the low-half sample of the next word
//   PK_HI | low half held in r_lo; next sample completes the word
module fir_out_stream
  import fir32_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_ce,
  input  logic signed [DATA_W-1:0]   i_is14_in,
  input  logic                       i_enable,
  input  logic signed [GAIN_W-1:0]   i_is16_gain,
  input  logic                       i_clr_flags,
  fir_out_stream_if.master           m_axis,
  output logic                       o_sat_flag,
  output logic                       o_ovf_flag,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);

  localparam int                FC_W    = $clog2(FRAME_LEN);
  localparam logic [FC_W-1:0]   FC_LAST = FC_W'(FRAME_LEN - 1);

  logic signed [PROD_W-1:0] r_prod;
  logic                     r_v1;
  logic signed [DATA_W-1:0] r_y;
  logic                     r_v2;
  sat_res_t                 w_sat;

  pack_state_e              r_state;
  pack_state_e              w_state_nxt;
  logic                     w_load_lo;
  logic                     w_emit;
  logic signed [DATA_W-1:0] r_lo;
  logic                     r_wr_vld;
  logic [OUT_W-1:0]         r_word;

  logic [FC_W-1:0]          r_frame_cnt;
  logic                     w_tlast;
  logic                     w_rd;
  logic                     w_wr_ok;
  logic                     w_drop;
  logic                     w_full;
  logic                     w_empty;
  logic [OUT_W:0]           w_rdata;

  assign w_sat = sat14(r_prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_prod <= '0;
      r_v2   <= 1'b0;
      r_y    <= '0;
    end else begin
      r_v1 <= i_ce & i_enable;
      if (i_ce & i_enable) r_prod <= PROD_W'(i_is14_in) * PROD_W'(i_is16_gain);
      r_v2 <= r_v1 & i_enable;
      if (r_v1) r_y <= w_sat.y;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_lo   = 1'b0;
    w_emit      = 1'b0;
    if (!i_enable) begin
      w_state_nxt = PK_LO;
    end else if (r_v2) begin
      case (r_state)
        PK_LO: begin
          w_load_lo   = 1'b1;
          w_state_nxt = PK_HI;
        end
        PK_HI: begin
          w_emit      = 1'b1;
          w_state_nxt = PK_LO;
        end
        default: w_state_nxt = PK_LO;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= PK_LO;
      r_lo     <= '0;
      r_wr_vld <= 1'b0;
      r_word   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_vld <= w_emit;
      if (w_load_lo) r_lo <= r_y;
      if (w_emit) r_word <= {16'(r_y), 16'(r_lo)};
    end
  end

  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign w_rd    = m_axis.tvalid & m_axis.tready;
  assign w_wr_ok = r_wr_vld & (~w_full | w_rd);
  assign w_drop  = r_wr_vld & w_full & ~w_rd;
  assign w_tlast = (r_frame_cnt == FC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (!i_enable) begin
      r_frame_cnt <= '0;
    end else if (w_wr_ok) begin
      r_frame_cnt <= (r_frame_cnt == FC_LAST) ? '0 : r_frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_sat_flag <= 1'b0;
      o_ovf_flag <= 1'b0;
    end else begin
      if (r_v1 & i_enable & w_sat.sat) o_sat_flag <= 1'b1;
      else if (i_clr_flags)            o_sat_flag <= 1'b0;
      if (w_drop)                      o_ovf_flag <= 1'b1;
      else if (i_clr_flags)            o_ovf_flag <= 1'b0;
    end
  end

  fir_out_fifo #(
    .WIDTH (OUT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_wr_ok),
    .i_wdata ({w_tlast, r_word}),
    .i_rd    (w_rd),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_fifo_level)
  );

  assign m_axis.tvalid = ~w_empty;
  assign m_axis.tlast  = w_rdata[OUT_W];
  assign m_axis.tdata  = w_rdata[OUT_W-1:0];

endmodule
